mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer for the E stage of the 5-stage MIPS pipeline.
- Owns HI/LO and the busy counter.
- Serves MFHI/MFLO reads into the E/M register's md path, and raises the stall request that holds the D stage while an operation is in flight.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_calc.sv | 59 +++++
 rtl/mdu_ctrl.sv | 103 ++++++++++
 tb/tb_mdu_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states, counter sizing.
// Optional MADD/MADDU support is enabled by defining MDU_MADD_EN.
package mdu_pkg;

   localparam logic [3:0] MD_NONE  = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MFHI  = 4'd5;
   localparam logic [3:0] MD_MFLO  = 4'd6;
   localparam logic [3:0] MD_MTHI  = 4'd7;
   localparam logic [3:0] MD_MTLO  = 4'd8;
   localparam logic [3:0] MD_MADD  = 4'd9;
   localparam logic [3:0] MD_MADDU = 4'd10;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   // Counter must hold the larger of the two latencies.
   function automatic int mdu_cnt_w(input int mult_cycles, input int div_cycles);
      int m;
      m = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational HI/LO result generator for mult/div (and MADD/MADDU under MDU_MADD_EN).
// Zero latency, no flow control; unrecognised ops pass current HI/LO through.
module mdu_calc
   import mdu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [63:0] hilo_n
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] rs_mag;
   logic [31:0] rt_mag;
   logic [31:0] div_s;
   logic [31:0] div_u;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] q_s;
   logic [31:0] r_s;
   logic [31:0] q_u;
   logic [31:0] r_u;
   logic        rt_zero;

   assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
   assign prod_u = {32'd0, rs} * {32'd0, rt};

   // Signed divide on magnitudes; 0x80000000/-1 falls out as quotient 0x80000000, remainder 0.
   assign rt_zero = (rt == 32'd0);
   assign rs_mag  = rs[31] ? (32'd0 - rs) : rs;
   assign rt_mag  = rt[31] ? (32'd0 - rt) : rt;
   assign div_s   = rt_zero ? 32'd1 : rt_mag;
   assign div_u   = rt_zero ? 32'd1 : rt;
   assign q_mag   = rs_mag / div_s;
   assign r_mag   = rs_mag % div_s;
   assign q_s     = (rs[31] ^ rt[31]) ? (32'd0 - q_mag) : q_mag;
   assign r_s     = rs[31] ? (32'd0 - r_mag) : r_mag;
   assign q_u     = rs / div_u;
   assign r_u     = rs % div_u;

   always_comb begin
      hilo_n = {hi, lo};
      case (op)
         MD_MULT:  hilo_n = prod_s;
         MD_MULTU: hilo_n = prod_u;
         MD_DIV:   hilo_n = rt_zero ? {hi, lo} : {r_s, q_s};
         MD_DIVU:  hilo_n = rt_zero ? {hi, lo} : {r_u, q_u};
`ifdef MDU_MADD_EN
         MD_MADD:  hilo_n = {hi, lo} + prod_s;
         MD_MADDU: hilo_n = {hi, lo} + prod_u;
`endif
         default:  hilo_n = {hi, lo};
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage mult/div sequencer owning HI/LO; MADD/MADDU accepted only with MDU_MADD_EN.
// Result commits MULT_CYCLES/DIV_CYCLES after accept; stall_req holds D while busy.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        md_valid,
   input  logic [3:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        d_is_md,
   output logic        start,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] md_out,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CW = mdu_cnt_w(MULT_CYCLES, DIV_CYCLES);
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

   logic [0:0]    state;
   logic [CW-1:0] cnt;
   logic [31:0]   pend_hi;
   logic [31:0]   pend_lo;
   logic [63:0]   hilo_n;
   logic          is_mul;
   logic          is_div;

   always_comb begin
      is_mul = 1'b0;
      is_div = 1'b0;
      case (md_op)
         MD_MULT, MD_MULTU: is_mul = 1'b1;
`ifdef MDU_MADD_EN
         MD_MADD, MD_MADDU: is_mul = 1'b1;
`endif
         MD_DIV, MD_DIVU:   is_div = 1'b1;
         default: ;
      endcase
   end

   assign busy      = (state == S_RUN);
   assign start     = md_valid & (is_mul | is_div) & ~busy;
   assign stall_req = d_is_md & (start | busy);

   mdu_calc u_calc (
      .op     (md_op),
      .rs     (rs_val),
      .rt     (rt_val),
      .hi     (hi),
      .lo     (lo),
      .hilo_n (hilo_n)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         hi      <= '0;
         lo      <= '0;
      end else if (state == S_IDLE) begin
         // Operands are captured only at accept; later forwarding changes don't matter.
         if (start) begin
            state   <= S_RUN;
            cnt     <= is_div ? DIV_LOAD : MULT_LOAD;
            pend_hi <= hilo_n[63:32];
            pend_lo <= hilo_n[31:0];
         end else if (md_valid && md_op == MD_MTHI) begin
            hi <= rs_val;
         end else if (md_valid && md_op == MD_MTLO) begin
            lo <= rs_val;
         end
      end else begin
         if (cnt == CW'(1)) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            cnt   <= '0;
            state <= S_IDLE;
         end else begin
            cnt <= cnt - CW'(1);
         end
      end
   end

   always_comb begin
      md_out = 32'd0;
      case (md_op)
         MD_MFHI: md_out = hi;
         MD_MFLO: md_out = lo;
         default: md_out = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed vector table, hand-written corner sequences, random run vs. reference model.
// MADD/MADDU expectations follow MDU_MADD_EN.
module tb_mdu_ctrl;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
   localparam int N_MUL = 5;
   localparam int N_DIV = 10;

   logic        clk;
   logic        reset;
   logic        md_valid;
   logic [3:0]  md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        d_is_md;
   logic        start;
   logic        busy;
   logic        stall_req;
   logic [31:0] md_out;
   logic [31:0] hi;
   logic [31:0] lo;

   int tests;
   int failed;

   mdu_ctrl #(.MULT_CYCLES(N_MUL), .DIV_CYCLES(N_DIV)) dut (
      .clk       (clk),
      .reset     (reset),
      .md_valid  (md_valid),
      .md_op     (md_op),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .d_is_md   (d_is_md),
      .start     (start),
      .busy      (busy),
      .stall_req (stall_req),
      .md_out    (md_out),
      .hi        (hi),
      .lo        (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] pre_hi;
      logic [31:0] pre_lo;
      int          cycles;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      md_valid = 1'b0;
      md_op    = OP_NONE;
      rs_val   = 32'd0;
      rt_val   = 32'd0;
   endtask

   task automatic preload(input logic [31:0] h, input logic [31:0] l);
      md_valid = 1'b1;
      md_op = OP_MTHI; rs_val = h; tick();
      md_op = OP_MTLO; rs_val = l; tick();
      idle_inputs();
   endtask

   task automatic do_reset();
      idle_inputs();
      d_is_md = 1'b0;
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   // Reference model: arithmetic straight from the instruction definitions.
   function automatic logic [63:0] ref_calc(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] h,
                                            input logic [31:0] l);
      int ia, ib;
      longint sa, sb;
      longint unsigned ua, ub;
      logic [63:0] r;
      ia = a; ib = b;
      sa = ia; sb = ib;
      ua = a; ub = b;
      r = {h, l};
      case (op)
         OP_MULT:  r = sa * sb;
         OP_MULTU: r = ua * ub;
         OP_DIV: begin
            if (b == 32'd0) r = {h, l};
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
            else r = {32'(ia % ib), 32'(ia / ib)};
         end
         OP_DIVU:  r = (b == 32'd0) ? {h, l} : {a % b, a / b};
         OP_MADD:  r = {h, l} + 64'(sa * sb);
         OP_MADDU: r = {h, l} + 64'(ua * ub);
         default:  r = {h, l};
      endcase
      return r;
   endfunction

   function automatic bit ref_long(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return (op >= OP_MULT && op <= OP_DIVU) || op == OP_MADD || op == OP_MADDU;
`else
      return (op >= OP_MULT && op <= OP_DIVU);
`endif
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         3: return 32'($urandom_range(0, 20));
         4: return 32'd0 - 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   vec_t vt[$];

   initial begin
      int n;
      logic [31:0] m_hi, m_lo;
      logic [63:0] m_pend;
      int m_done, cyc;
      bit m_busy, v, dm, e_start;
      logic [3:0] op;
      logic [31:0] a, b;

      tests = 0;
      failed = 0;
      reset = 1'b0;
      d_is_md = 1'b0;
      idle_inputs();

      vt.push_back('{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'd0,  32'd0,  N_MUL, 32'hFFFFFFFF, 32'hFFFFFFFA});
      vt.push_back('{OP_MULTU, 32'hFFFFFFFE, 32'd3,        32'd0,  32'd0,  N_MUL, 32'h00000002, 32'hFFFFFFFA});
      vt.push_back('{OP_MULT,  32'h80000000, 32'h80000000, 32'd1,  32'd1,  N_MUL, 32'h40000000, 32'h00000000});
      vt.push_back('{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'd0,  32'd0,  N_DIV, 32'hFFFFFFFF, 32'hFFFFFFFD});
      vt.push_back('{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd0,  32'd0,  N_DIV, 32'h00000001, 32'hFFFFFFFD});
      vt.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd9,  32'd9,  N_DIV, 32'h00000000, 32'h80000000});
      vt.push_back('{OP_DIV,   32'd100,      32'd0,        32'd5,  32'd6,  N_DIV, 32'h00000005, 32'h00000006});
      vt.push_back('{OP_DIVU,  32'd7,        32'd0,        32'h11, 32'h22, N_DIV, 32'h00000011, 32'h00000022});
      vt.push_back('{OP_DIVU,  32'hFFFFFFFF, 32'd2,        32'd0,  32'd0,  N_DIV, 32'h00000001, 32'h7FFFFFFF});
`ifdef MDU_MADD_EN
      vt.push_back('{OP_MADDU, 32'd1,        32'd1,        32'd0,  32'hFFFFFFFF, N_MUL, 32'h00000001, 32'h00000000});
      vt.push_back('{OP_MADD,  32'hFFFFFFFF, 32'd2,        32'd0,  32'd0,  N_MUL, 32'hFFFFFFFF, 32'hFFFFFFFE});
`else
      vt.push_back('{OP_MADDU, 32'd1,        32'd1,        32'd0,  32'hFFFFFFFF, 0, 32'h00000000, 32'hFFFFFFFF});
      vt.push_back('{OP_MADD,  32'hFFFFFFFF, 32'd2,        32'd3,  32'd4,  0,     32'h00000003, 32'h00000004});
`endif

      // Reset state
      tick();
      md_op = OP_MFHI; #1;
      check("reset busy", 32'(busy), 32'd0);
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      check("reset md_out", md_out, 32'd0);
      reset = 1'b1;
      idle_inputs();
      tick();

      // Directed vector table
      foreach (vt[i]) begin
         preload(vt[i].pre_hi, vt[i].pre_lo);
         md_valid = 1'b1;
         md_op    = vt[i].op;
         rs_val   = vt[i].rs;
         rt_val   = vt[i].rt;
         #1;
         check($sformatf("vec%0d start", i), 32'(start), 32'(vt[i].cycles > 0));
         tick();
         idle_inputs();
         n = 0;
         while (busy && n < 60) begin
            check($sformatf("vec%0d hidden pending", i), hi, vt[i].pre_hi);
            n++;
            tick();
         end
         check($sformatf("vec%0d busy cycles", i), 32'(n), 32'(vt[i].cycles));
         check($sformatf("vec%0d hi", i), hi, vt[i].exp_hi);
         check($sformatf("vec%0d lo", i), lo, vt[i].exp_lo);
      end

      // Stall window around a MULT, then MFLO of the new result
      d_is_md = 1'b1;
      md_valid = 1'b1; md_op = OP_MULT; rs_val = 32'd6; rt_val = 32'd7;
      #1;
      check("stall start cycle", 32'(stall_req), 32'd1);
      tick();
      idle_inputs();
      for (int k = 0; k < N_MUL; k++) begin
         check($sformatf("stall busy cycle %0d", k), 32'(stall_req), 32'd1);
         tick();
      end
      check("stall released", 32'(stall_req), 32'd0);
      check("busy released", 32'(busy), 32'd0);
      md_valid = 1'b1; md_op = OP_MFLO; #1;
      check("mflo after mult", md_out, 32'd42);
      idle_inputs();
      d_is_md = 1'b0;
      tick();

      // MTHI while idle
      md_valid = 1'b1; md_op = OP_MTHI; rs_val = 32'hDEADBEEF;
      tick();
      idle_inputs();
      check("mthi busy", 32'(busy), 32'd0);
      check("mthi hi", hi, 32'hDEADBEEF);
      md_op = OP_MFHI; #1;
      check("mfhi md_out", md_out, 32'hDEADBEEF);
      idle_inputs();
      tick();

      // Reset during an in-flight DIV aborts it
      md_valid = 1'b1; md_op = OP_DIV; rs_val = 32'd100; rt_val = 32'd7;
      tick();
      idle_inputs();
      tick(); tick(); tick();
      reset = 1'b0;
      #1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort hi", hi, 32'd0);
      check("abort lo", lo, 32'd0);
      tick();
      reset = 1'b1;
      for (int k = 0; k < N_DIV + 2; k++) tick();
      check("no late commit hi", hi, 32'd0);
      check("no late commit lo", lo, 32'd0);
      check("no late busy", 32'(busy), 32'd0);

      // Random run against the reference model
      do_reset();
      m_hi = 32'd0; m_lo = 32'd0; m_pend = 64'd0; m_done = 0; cyc = 0;
      for (int i = 0; i < 600; i++) begin
         m_busy = (cyc < m_done);
         v  = ($urandom_range(0, 3) != 0);
         op = 4'($urandom_range(0, 15));
         if (m_busy && op >= OP_MFHI && op <= OP_MTLO) op = OP_NONE;
         a  = pick_operand();
         b  = pick_operand();
         dm = $urandom_range(0, 1);
         md_valid = v; md_op = op; rs_val = a; rt_val = b; d_is_md = dm;
         #1;
         e_start = v && ref_long(op) && !m_busy;
         check("rnd start", 32'(start), 32'(e_start));
         check("rnd busy", 32'(busy), 32'(m_busy));
         check("rnd stall_req", 32'(stall_req), 32'(dm && (e_start || m_busy)));
         check("rnd md_out", md_out, (op == OP_MFHI) ? m_hi : (op == OP_MFLO) ? m_lo : 32'd0);
         check("rnd hi", hi, m_hi);
         check("rnd lo", lo, m_lo);
         if (m_busy) begin
            if (cyc + 1 == m_done) {m_hi, m_lo} = m_pend;
         end else if (e_start) begin
            m_pend = ref_calc(op, a, b, m_hi, m_lo);
            m_done = cyc + 1 + ((op == OP_DIV || op == OP_DIVU) ? N_DIV : N_MUL);
         end else if (v && op == OP_MTHI) begin
            m_hi = a;
         end else if (v && op == OP_MTLO) begin
            m_lo = a;
         end
         cyc++;
         tick();
      end
      idle_inputs();
      d_is_md = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
